// File: rtl/serial_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_deserializer_pkg
// Shared definitions for the bit-serial receive path.
//   - deser_state_t : deserializer FSM state encoding
//   - DEFAULT_WORD_W : default parallel word width
// Optional feature macro used by importers: DESER_PARITY_EN
// -----------------------------------------------------------------------------
package serial_deserializer_pkg;

    localparam int DEFAULT_WORD_W = 8;

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_PARITY = 2'd1,
        ST_HOLD   = 2'd2
    } deser_state_t;

endpackage : serial_deserializer_pkg

// File: rtl/serial_bit_counter.sv
// -----------------------------------------------------------------------------
// serial_bit_counter
// Frame bit counter for bit-serial datapaths. Counts 0..WIDTH-1 and wraps to 0
// on the increment after WIDTH-1. Shared by serializer and deserializer sides.
//
// Ports:
//   clk   in   clock
//   rstn  in   synchronous active-low reset (count -> 0)
//   clr   in   synchronous clear (count -> 0), priority over en
//   en    in   advance the count by one
//   count out  current bit index (CNT_W bits)
//   last  out  count == WIDTH-1
// -----------------------------------------------------------------------------
module serial_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    assign last  = (r_count == CNT_W'(WIDTH - 1));
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            // Explicit wrap so non-power-of-two widths restart cleanly.
            if (last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : serial_bit_counter

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
// Collects a bit-serial stream (LSB first) into WIDTH-bit words and presents
// each completed word on a valid/ready port. One output slot plus the shift
// register itself acting as a hold buffer gives lossless 1 bit/cycle operation
// while the consumer keeps word_ready high.
//
// Optional feature: define DESER_PARITY_EN to append one even-parity bit to
// every frame; word_perr then reports the parity check result for word_o.
// Without it the frame is WIDTH bits and word_perr is tied to 0.
//
// Ports:
//   clk         in   clock
//   rstn        in   synchronous active-low reset
//   clr         in   synchronous abort, drops the partial/held frame
//   bit_in      in   serial data bit
//   bit_valid   in   bit_in valid this cycle
//   bit_ready   out  a bit can be accepted this cycle
//   word_o      out  assembled word, bit 0 = first bit received
//   word_valid  out  word_o holds an unconsumed word
//   word_ready  in   consumer accepts word_o
//   word_perr   out  parity error flag for word_o
//   busy        out  partial frame in progress
//   bit_index   out  index of next data bit expected
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SHIFT  | collecting data bits, bit_ready = 1
// ST_PARITY | data complete, waiting for the parity bit (feature only)
// ST_HOLD   | complete frame parked in the shift register, bit_ready = 0
// -----------------------------------------------------------------------------
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WORD_W,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_perr,
    output logic             busy,
    output logic [CNT_W-1:0] bit_index
);

    deser_state_t     r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
    logic             r_bit_ready;

    logic             w_bit_acc;
    logic             w_data_acc;
    logic             w_last;
    logic             w_slot_free;
    logic             w_consume;

    assign w_bit_acc   = bit_valid && r_bit_ready && !clr;
    assign w_data_acc  = w_bit_acc && (r_state == ST_SHIFT);
    assign w_consume   = r_word_valid && word_ready;
    // The output slot can take a new word if it is empty or being emptied now.
    assign w_slot_free = !r_word_valid || word_ready;

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .en    (w_data_acc),
        .count (bit_index),
        .last  (w_last)
    );

`ifdef DESER_PARITY_EN
    logic r_perr;
    logic r_perr_hold;
    logic w_perr_calc;

    // Even parity: XOR of all data bits and the parity bit must be 0.
    assign w_perr_calc = (^r_shift) ^ bit_in;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_SHIFT;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_bit_ready  <= 1'b0;
            r_perr       <= 1'b0;
            r_perr_hold  <= 1'b0;
        end else begin
            // Consumption clears the slot unless a new word lands below.
            if (w_consume) begin
                r_word_valid <= 1'b0;
            end
            if (clr) begin
                r_state     <= ST_SHIFT;
                r_shift     <= '0;
                r_bit_ready <= 1'b1;
                r_perr_hold <= 1'b0;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        r_bit_ready <= 1'b1;
                        if (w_bit_acc) begin
                            r_shift[bit_index] <= bit_in;
                            if (w_last) begin
                                r_state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        r_bit_ready <= 1'b1;
                        if (w_bit_acc) begin
                            if (w_slot_free) begin
                                r_word       <= r_shift;
                                r_perr       <= w_perr_calc;
                                r_word_valid <= 1'b1;
                                r_state      <= ST_SHIFT;
                            end else begin
                                r_perr_hold  <= w_perr_calc;
                                r_bit_ready  <= 1'b0;
                                r_state      <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_consume) begin
                            r_word       <= r_shift;
                            r_perr       <= r_perr_hold;
                            r_word_valid <= 1'b1;
                            r_bit_ready  <= 1'b1;
                            r_state      <= ST_SHIFT;
                        end else begin
                            r_bit_ready  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= ST_SHIFT;
                        r_bit_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign word_perr = r_perr;
`else
    logic [WIDTH-1:0] w_frame;

    // Full frame including the bit being accepted this cycle, so the word can
    // be loaded on the same edge as the last bit.
    always_comb begin
        w_frame            = r_shift;
        w_frame[bit_index] = bit_in;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_SHIFT;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_bit_ready  <= 1'b0;
        end else begin
            if (w_consume) begin
                r_word_valid <= 1'b0;
            end
            if (clr) begin
                r_state     <= ST_SHIFT;
                r_shift     <= '0;
                r_bit_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        r_bit_ready <= 1'b1;
                        if (w_bit_acc) begin
                            r_shift[bit_index] <= bit_in;
                            if (w_last) begin
                                if (w_slot_free) begin
                                    r_word       <= w_frame;
                                    r_word_valid <= 1'b1;
                                end else begin
                                    // Shift register becomes the hold buffer.
                                    r_bit_ready  <= 1'b0;
                                    r_state      <= ST_HOLD;
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_consume) begin
                            r_word       <= r_shift;
                            r_word_valid <= 1'b1;
                            r_bit_ready  <= 1'b1;
                            r_state      <= ST_SHIFT;
                        end else begin
                            r_bit_ready  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= ST_SHIFT;
                        r_bit_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign word_perr = 1'b0;
`endif

    assign bit_ready  = r_bit_ready;
    assign word_o     = r_word;
    assign word_valid = r_word_valid;
    assign busy       = (bit_index != '0) || (r_state != ST_SHIFT);

endmodule : serial_deserializer
